// File: rtl/mem_pkg.sv
// Shared constants and helpers for the memory-access stage: funct3 encodings,
// FSM state encoding and the load/store legality check.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t ACCESS = 1'b1;

    // True when a memory op is well-formed and naturally aligned.
    function automatic logic mem_legal(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd && wr) begin
            ok = 1'b0;
        end else if (rd) begin
            case (f3)
                F3_B, F3_BU: ok = 1'b1;
                F3_H, F3_HU: ok = ~off[0];
                F3_W:        ok = (off == 2'b00);
                default:     ok = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = ~off[0];
                F3_W:    ok = (off == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Picks the addressed byte/half/word out of a read word and sign- or
// zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_i[{addr_i, 3'b000} +: 8];
        half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_v[7]}}, byte_v};
            F3_H:    data_o = {{16{half_v[15]}}, half_v};
            F3_BU:   data_o = {24'h0, byte_v};
            F3_HU:   data_o = {16'h0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores on a request/ack data-memory
// port, stalls upstream while busy and registers the writeback bundle.
module memory_access
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic              w_reg_in,
    input  logic [4:0]        dst_addr_in,
    input  logic [XLEN-1:0]   next_pc_in,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,
    output logic              w_reg,
    output logic [XLEN-1:0]   rd_data,
    output logic [4:0]        dst_addr,
    output logic [XLEN-1:0]   next_pcD,
    output logic              mem_fault
);

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic                w_reg_q, w_reg_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [4:0]          dst_q, dst_d;
    logic [XLEN-1:0]     npc_q, npc_d;
    logic                fault_q, fault_d;

    // Instruction context held across the access.
    logic [1:0]          off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic                wlat_q, wlat_d;
    logic [4:0]          dlat_q, dlat_d;
    logic [XLEN-1:0]     plat_q, plat_d;

    logic                mem_op, legal, start;
    logic [XLEN-1:0]     load_val;

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (off_q),
        .funct3_i (f3_q),
        .data_o   (load_val)
    );

    always_comb begin
        mem_op = mem_read | mem_write;
        legal  = mem_legal(mem_read, mem_write, funct3, alu_result[1:0]);
        start  = (state_q == IDLE) & ex_valid & mem_op & legal;
        stall  = (state_q == ACCESS) | start;
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        w_reg_d   = 1'b0;
        rd_data_d = rd_data_q;
        dst_d     = dst_q;
        npc_d     = npc_q;
        fault_d   = 1'b0;
        off_d     = off_q;
        f3_d      = f3_q;
        wlat_d    = wlat_q;
        dlat_d    = dlat_q;
        plat_d    = plat_q;

        case (state_q)
            IDLE: begin
                if (ex_valid && !mem_op) begin
                    w_reg_d   = w_reg_in;
                    rd_data_d = alu_result;
                    dst_d     = dst_addr_in;
                    npc_d     = next_pc_in;
                end else if (start) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
                    off_d   = alu_result[1:0];
                    f3_d    = funct3;
                    wlat_d  = w_reg_in;
                    dlat_d  = dst_addr_in;
                    plat_d  = next_pc_in;
                    if (mem_write) begin
                        case (funct3)
                            F3_B: begin
                                be_d    = 4'b0001 << alu_result[1:0];
                                wdata_d = {4{store_data[7:0]}};
                            end
                            F3_H: begin
                                be_d    = 4'b0011 << alu_result[1:0];
                                wdata_d = {2{store_data[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = store_data;
                            end
                        endcase
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = '0;
                    end
                end else if (ex_valid) begin
                    fault_d = 1'b1;
                end
            end
            default: begin
                if (dmem_ack) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    rd_data_d = we_q ? '0 : load_val;
                    w_reg_d   = wlat_q & ~we_q;
                    dst_d     = dlat_q;
                    npc_d     = plat_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            w_reg_q   <= 1'b0;
            rd_data_q <= '0;
            dst_q     <= '0;
            npc_q     <= '0;
            fault_q   <= 1'b0;
            off_q     <= '0;
            f3_q      <= '0;
            wlat_q    <= 1'b0;
            dlat_q    <= '0;
            plat_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            w_reg_q   <= w_reg_d;
            rd_data_q <= rd_data_d;
            dst_q     <= dst_d;
            npc_q     <= npc_d;
            fault_q   <= fault_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            wlat_q    <= wlat_d;
            dlat_q    <= dlat_d;
            plat_q    <= plat_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign w_reg      = w_reg_q;
    assign rd_data    = rd_data_q;
    assign dst_addr   = dst_q;
    assign next_pcD   = npc_q;
    assign mem_fault  = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a vector table of single operations with
// one-cycle ack, plus hand-written multi-cycle sequences.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        w_reg_in = 1'b0;
    logic [4:0]  dst_addr_in = '0;
    logic [31:0] next_pc_in = '0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        w_reg;
    logic [31:0] rd_data;
    logic [4:0]  dst_addr;
    logic [31:0] next_pcD;
    logic        mem_fault;

    memory_access #(.ADDR_W(32), .XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .w_reg_in    (w_reg_in),
        .dst_addr_in (dst_addr_in),
        .next_pc_in  (next_pc_in),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .w_reg       (w_reg),
        .rd_data     (rd_data),
        .dst_addr    (dst_addr),
        .next_pcD    (next_pcD),
        .mem_fault   (mem_fault)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] K_PASS = 2'd0, K_MEM = 2'd1, K_FAULT = 2'd2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic        wreg_in;
        logic [1:0]  kind;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_wreg;
    } vec_t;

    vec_t vecs[16];
    int   n_total = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic wi,
                         input logic [4:0] dst, input logic [31:0] npc);
        ex_valid = ev; mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a;
        store_data = sd; w_reg_in = wi; dst_addr_in = dst; next_pc_in = npc;
    endtask

    task automatic idle_in;
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rdat, input logic wi, input logic [1:0] k,
                                input logic [31:0] ea, input logic [3:0] be,
                                input logic [31:0] ewd, input logic [31:0] erd,
                                input logic ew);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.sd = sd; v.rdata = rdat;
        v.wreg_in = wi; v.kind = k; v.e_addr = ea; v.e_be = be; v.e_wdata = ewd;
        v.e_rd = erd; v.e_wreg = ew;
        return v;
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        logic [4:0]  dst;
        logic [31:0] npc;
        dst = 5'(i + 3);
        npc = 32'h1000 + 32'(i * 4);
        drive(1'b1, v.rd, v.wr, v.f3, v.addr, v.sd, v.wreg_in, dst, npc);
        #1;
        chk($sformatf("v%0d stall", i), {31'h0, stall}, {31'h0, v.kind == K_MEM});
        tick;
        idle_in;
        if (v.kind == K_PASS) begin
            chk($sformatf("v%0d w_reg", i), {31'h0, w_reg}, {31'h0, v.e_wreg});
            chk($sformatf("v%0d rd_data", i), rd_data, v.e_rd);
            chk($sformatf("v%0d dst", i), {27'h0, dst_addr}, {27'h0, dst});
            chk($sformatf("v%0d npc", i), next_pcD, npc);
            chk($sformatf("v%0d fault", i), {31'h0, mem_fault}, 32'h0);
        end else if (v.kind == K_FAULT) begin
            chk($sformatf("v%0d fault", i), {31'h0, mem_fault}, 32'h1);
            chk($sformatf("v%0d req", i), {31'h0, dmem_req}, 32'h0);
            chk($sformatf("v%0d w_reg", i), {31'h0, w_reg}, 32'h0);
            #1;
            chk($sformatf("v%0d stall", i), {31'h0, stall}, 32'h0);
            tick;
            chk($sformatf("v%0d fault pulse", i), {31'h0, mem_fault}, 32'h0);
        end else begin
            chk($sformatf("v%0d req", i), {31'h0, dmem_req}, 32'h1);
            chk($sformatf("v%0d we", i), {31'h0, dmem_we}, {31'h0, v.wr});
            chk($sformatf("v%0d addr", i), dmem_addr, v.e_addr);
            chk($sformatf("v%0d be", i), {28'h0, dmem_be}, {28'h0, v.e_be});
            if (v.wr) chk($sformatf("v%0d wdata", i), dmem_wdata, v.e_wdata);
            chk($sformatf("v%0d w_reg busy", i), {31'h0, w_reg}, 32'h0);
            dmem_rdata = v.rdata;
            dmem_ack = 1'b1;
            tick;
            dmem_ack = 1'b0;
            chk($sformatf("v%0d req drop", i), {31'h0, dmem_req}, 32'h0);
            chk($sformatf("v%0d rd_data", i), rd_data, v.e_rd);
            chk($sformatf("v%0d w_reg", i), {31'h0, w_reg}, {31'h0, v.e_wreg});
            chk($sformatf("v%0d dst", i), {27'h0, dst_addr}, {27'h0, dst});
            chk($sformatf("v%0d npc", i), next_pcD, npc);
        end
    endtask

    initial begin
        int          nstall;
        logic [31:0] keep_rd;

        vecs[0]  = mk(0, 0, 3'b000, 32'h0000_1234, 0, 0, 1, K_PASS, 0, 0, 0, 32'h0000_1234, 1);
        vecs[1]  = mk(1, 0, 3'b000, 32'h103, 0, 32'h80FF_0011, 1, K_MEM, 32'h100, 4'hF, 0,
                      32'hFFFF_FF80, 1);
        vecs[2]  = mk(1, 0, 3'b100, 32'h103, 0, 32'h80FF_0011, 1, K_MEM, 32'h100, 4'hF, 0,
                      32'h0000_0080, 1);
        vecs[3]  = mk(1, 0, 3'b001, 32'h102, 0, 32'h80FF_0011, 1, K_MEM, 32'h100, 4'hF, 0,
                      32'hFFFF_80FF, 1);
        vecs[4]  = mk(1, 0, 3'b101, 32'h100, 0, 32'h80FF_8011, 1, K_MEM, 32'h100, 4'hF, 0,
                      32'h0000_8011, 1);
        vecs[5]  = mk(1, 0, 3'b010, 32'h104, 0, 32'hDEAD_BEEF, 1, K_MEM, 32'h104, 4'hF, 0,
                      32'hDEAD_BEEF, 1);
        vecs[6]  = mk(1, 0, 3'b000, 32'h101, 0, 32'h1234_7F56, 1, K_MEM, 32'h100, 4'hF, 0,
                      32'h0000_007F, 1);
        vecs[7]  = mk(0, 1, 3'b001, 32'h202, 32'hABCD_5678, 32'hFFFF_FFFF, 1, K_MEM, 32'h200,
                      4'b1100, 32'h5678_5678, 0, 0);
        vecs[8]  = mk(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0, 1, K_MEM, 32'h300, 4'b0010,
                      32'hA5A5_A5A5, 0, 0);
        vecs[9]  = mk(0, 1, 3'b010, 32'h400, 32'h1122_3344, 0, 1, K_MEM, 32'h400, 4'hF,
                      32'h1122_3344, 0, 0);
        vecs[10] = mk(1, 0, 3'b010, 32'h101, 0, 0, 1, K_FAULT, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 3'b001, 32'h203, 32'h55, 0, 1, K_FAULT, 0, 0, 0, 0, 0);
        vecs[12] = mk(1, 0, 3'b011, 32'h100, 0, 0, 1, K_FAULT, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 3'b100, 32'h100, 32'h77, 0, 1, K_FAULT, 0, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 3'b010, 32'h100, 0, 0, 1, K_FAULT, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 3'b000, 32'h0000_CAFE, 0, 0, 0, K_PASS, 0, 0, 0, 32'h0000_CAFE, 0);

        // Reset state
        #2 rst_n = 1'b0;
        tick; tick;
        chk("reset outputs", {dmem_req, dmem_we, w_reg, mem_fault, dmem_be, dst_addr},
            32'h0);
        chk("reset rd_data", rd_data | next_pcD | dmem_addr | dmem_wdata, 32'h0);
        chk("reset stall", {31'h0, stall}, 32'h0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // LB with ack in the third ACCESS cycle: four stall cycles total
        nstall = 0;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd9, 32'h2000);
        #1;
        if (stall) nstall++;
        tick;
        idle_in;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lb busy req c%0d", c), {31'h0, dmem_req}, 32'h1);
            chk($sformatf("lb busy w_reg c%0d", c), {31'h0, w_reg}, 32'h0);
            chk($sformatf("lb addr c%0d", c), dmem_addr, 32'h100);
            if (stall) nstall++;
            if (c == 2) begin
                dmem_rdata = 32'h80FF_0011;
                dmem_ack = 1'b1;
            end
            tick;
        end
        dmem_ack = 1'b0;
        chk("lb stall cycles", 32'(nstall), 32'd4);
        chk("lb rd_data", rd_data, 32'hFFFF_FF80);
        chk("lb w_reg", {31'h0, w_reg}, 32'h1);
        #1;
        chk("lb stall after", {31'h0, stall}, 32'h0);

        // Spurious ack in IDLE
        tick;
        keep_rd = rd_data;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
        #1;
        chk("spurious stall", {31'h0, stall}, 32'h0);
        tick;
        dmem_ack = 1'b0;
        chk("spurious req", {31'h0, dmem_req}, 32'h0);
        chk("spurious rd_data", rd_data, keep_rd);
        chk("spurious w_reg", {31'h0, w_reg}, 32'h0);

        // Back-to-back LW then SW with ack held high
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0102_0304;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 5'd12, 32'h3000);
        tick;
        chk("b2b lw req", {31'h0, dmem_req}, 32'h1);
        chk("b2b lw we", {31'h0, dmem_we}, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h504, 32'hCAFE_F00D, 1'b1, 5'd13, 32'h3004);
        tick;
        chk("b2b lw done req", {31'h0, dmem_req}, 32'h0);
        chk("b2b lw rd_data", rd_data, 32'h0102_0304);
        chk("b2b lw w_reg", {31'h0, w_reg}, 32'h1);
        chk("b2b lw dst", {27'h0, dst_addr}, 32'd12);
        #1;
        chk("b2b sw stall", {31'h0, stall}, 32'h1);
        tick;
        idle_in;
        chk("b2b sw req", {31'h0, dmem_req}, 32'h1);
        chk("b2b sw we", {31'h0, dmem_we}, 32'h1);
        chk("b2b sw wdata", dmem_wdata, 32'hCAFE_F00D);
        tick;
        dmem_ack = 1'b0;
        chk("b2b sw done req", {31'h0, dmem_req}, 32'h0);
        chk("b2b sw w_reg", {31'h0, w_reg}, 32'h0);
        chk("b2b sw rd_data", rd_data, 32'h0);
        chk("b2b sw npc", next_pcD, 32'h3004);

        // Reset asserted mid-ACCESS
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h5555_AAAA, 32'h0, 1'b1, 5'd21, 32'h4000);
        tick;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 1'b1, 5'd22, 32'h4004);
        tick;
        idle_in;
        chk("pre-reset req", {31'h0, dmem_req}, 32'h1);
        chk("pre-reset rd_data", rd_data, 32'h5555_AAAA);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset req", {31'h0, dmem_req}, 32'h0);
        chk("async reset ctl", {dmem_we, w_reg, mem_fault, dmem_be, dst_addr}, 32'h0);
        chk("async reset data", rd_data | next_pcD | dmem_addr | dmem_wdata, 32'h0);
        tick;
        rst_n = 1'b1;
        #1;
        chk("post-reset stall", {31'h0, stall}, 32'h0);
        tick;
        chk("post-reset req", {31'h0, dmem_req}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory-access stage of the 5-stage pipeline; sits between execute and writeback.
- Performs loads and stores through a single-port, variable-latency data-memory request/ack interface.
- Aligns and sign/zero-extends load data.
- Registers the result bundle the writeback stage consumes: w_reg, rd_data, dst_addr, next_pcD.
- Stalls upstream while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction this cycle.
- alu_result  in  32  effective address (loads/stores) or pass-through result.
- store_data  in  32  rs2 value for stores.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- w_reg_in  in  1  instruction writes rd.
- dst_addr_in  in  5  rd index.
- next_pc_in  in  32  next PC from execute.
- stall  out  1  upstream must hold its outputs (combinational).
- dmem_req  out  1  memory request; held high until ack.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read word, valid with ack.
- dmem_ack  in  1  one-cycle completion pulse.
- w_reg  out  1  to writeback: write enable.
- rd_data  out  32  to writeback: result.
- dst_addr  out  5  to writeback: rd index.
- next_pcD  out  32  to writeback: next PC.
- mem_fault  out  1  one-cycle pulse: misaligned or illegal access.

Behaviour:
Reset:
- rst_n low asynchronously forces state IDLE and clears every output and internal register to 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, w_reg, rd_data, dst_addr, next_pcD, mem_fault.
- Reset during ACCESS abandons the request; dmem_req drops immediately.

State machine:
- IDLE:
  - Non-memory op (ex_valid, neither mem_read nor mem_write): next edge registers w_reg=w_reg_in, rd_data=alu_result, dst_addr, next_pcD. Latency 1, no stall.
  - Legal aligned memory op: latch address, funct3, dst, next_pc and w_reg_in. Drive dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata registered next edge. Go to ACCESS. stall=1 this cycle.
  - Illegal op: no request. Output bubble (w_reg=0) with mem_fault=1 for one cycle. Stay IDLE.
  - ex_valid=0: output bubble (w_reg=0; other outputs hold).
- ACCESS:
  - stall=1.
  - Request signals held stable until dmem_ack.
  - On the ack edge: dmem_req=0; outputs rd_data (load: extracted value; store: 0), w_reg = latched w_reg_in AND load, dst_addr, next_pcD. Return to IDLE.
  - Without ack: w_reg=0 every cycle.
  - Minimum memory-op latency is 2 cycles (ack in the first ACCESS cycle).
- dmem_ack while in IDLE is ignored.

Illegal/misaligned:
- mem_read and mem_write both set.
- Load funct3 in {011, 110, 111}; store funct3 not in {000, 001, 010}.
- H/HU/SH with addr[0]=1.
- W/SW with addr[1:0]≠0.

Store lanes:
- SB: be = 0001<<addr[1:0], wdata = {4{sd[7:0]}}.
- SH: be = 0011<<addr[1:0], wdata = {2{sd[15:0]}}.
- SW: be = 1111.

Load extract:
- Byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
- B/H sign-extend; BU/HU zero-extend.
- For loads dmem_be = 1111 and dmem_we = 0.

stall:
- stall = (state==ACCESS) | (state==IDLE & ex_valid & (mem_read|mem_write) & legal).

Decomposition:
- Package mem_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum (IDLE, ACCESS), and a legality function.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output extended 32-bit value.
- Store lane/be generation stays inline.

Test Plan:
1. Reset: rst_n=0 mid-ACCESS with dmem_req=1 → dmem_req=0 and all outputs 0 immediately; after release, IDLE, stall=0.
2. Pass-through: ALU op, alu_result=0x1234, dst=5, w_reg_in=1 → next cycle w_reg=1, rd_data=0x1234, dst_addr=5, no stall.
3. LB at 0x103 with rdata=0x80FF_0011 and ack after 3 cycles → stall high 4 cycles, then rd_data=0xFFFF_FF80, dmem_addr=0x100; LBU at the same address → 0x0000_0080.
4. SH at 0x202, store_data=0xABCD_5678 → dmem_be=1100, dmem_wdata=0x5678_5678, dmem_we=1; after ack, w_reg=0.
5. LW at 0x101 → no dmem_req, mem_fault=1 for one cycle, w_reg=0, stall=0.
6. Spurious dmem_ack in IDLE with no op → no output change; back-to-back LW/SW sequence with ack held high continuously → one access completes per 2 cycles.
